// File: rtl/led_pulse_stretcher_pkg.sv
// Shared definitions for the LED pulse stretcher: FSM encoding and 50 MHz timing defaults.
package led_pkg;

  // 2'd3 is unused and recovers to IDLE in the FSM.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int ON_CYCLES_DEF  = 5_000_000;
  localparam int OFF_CYCLES_DEF = 2_500_000;
  localparam int CNT_W_DEF      = 26;

endpackage

// File: rtl/led_pulse_stretcher_if.sv
// Event-strobe in, LED/status out; master is the strobe source, slave is the stretcher.
interface led_pulse_stretcher_if;

  logic tick_i;
  logic led_o;
  logic busy_o;
  logic pend_o;

  modport master (output tick_i, input led_o, input busy_o, input pend_o);
  modport slave  (input tick_i, output led_o, output busy_o, output pend_o);

endinterface

// File: rtl/led_pulse_stretcher_interval_counter.sv
// Up-counter with clear (priority), enable and an equality terminal-count flag.
module interval_counter #(
  parameter int CNT_W = 26
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term_val,
  output logic             at_term
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)    count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + CNT_W'(1);
  end

  assign at_term = (count == term_val);

endmodule

// File: rtl/led_pulse_stretcher.sv
// Stretches single-cycle ticks into LED blinks with guaranteed on-time and dark gap.
// Define LED_STRETCH_RETRIGGER_EN to make ticks during ON extend the current blink.
module led_pulse_stretcher
  import led_pkg::*;
#(
  parameter int ON_CYCLES  = ON_CYCLES_DEF,
  parameter int OFF_CYCLES = OFF_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  led_pulse_stretcher_if.slave  bus
);

`ifdef LED_STRETCH_RETRIGGER_EN
  localparam bit RETRIGGER = 1'b1;
`else
  localparam bit RETRIGGER = 1'b0;
`endif

  localparam logic [CNT_W-1:0] ON_TERM  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_TERM = CNT_W'(OFF_CYCLES - 1);

  state_e           state, state_nx;
  logic             at_term, cnt_clr, cnt_en;
  logic             led_nx, busy_nx, pend_nx;
  logic [CNT_W-1:0] term_val;

  assign term_val = (state == GAP) ? OFF_TERM : ON_TERM;
  assign cnt_en   = (state == ON) || (state == GAP);

  interval_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .term_val (term_val),
    .at_term  (at_term)
  );

  // Outputs are registered from next-state values so led_o rises on the tick's edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      bus.led_o  <= 1'b0;
      bus.busy_o <= 1'b0;
      bus.pend_o <= 1'b0;
    end else begin
      state      <= state_nx;
      bus.led_o  <= led_nx;
      bus.busy_o <= busy_nx;
      bus.pend_o <= pend_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.tick_i) state_nx = ON;
      ON:      if (at_term && !(RETRIGGER && bus.tick_i)) state_nx = GAP;
      GAP:     if (at_term) state_nx = (bus.pend_o || bus.tick_i) ? ON : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    cnt_clr = 1'b0;
    pend_nx = bus.pend_o;
    case (state)
      IDLE: cnt_clr = bus.tick_i;
      ON: begin
        if (RETRIGGER && bus.tick_i) begin
          cnt_clr = 1'b1;
        end else begin
          if (bus.tick_i) pend_nx = 1'b1;
          if (at_term)    cnt_clr = 1'b1;
        end
      end
      GAP: begin
        if (at_term) begin
          cnt_clr = 1'b1;
          pend_nx = 1'b0;
        end else if (bus.tick_i) begin
          pend_nx = 1'b1;
        end
      end
      default: begin
        cnt_clr = 1'b1;
        pend_nx = 1'b0;
      end
    endcase
    led_nx  = (state_nx == ON);
    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench with a behavioural reference model feeding a per-cycle scoreboard.
module tb_led_pulse_stretcher;

  localparam int ON  = 4;
  localparam int OFF = 3;

`ifdef LED_STRETCH_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  typedef struct {
    logic led;
    logic busy;
    logic pend;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  led_pulse_stretcher_if bus ();

  led_pulse_stretcher #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .CNT_W(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   edge_n     = 0;
  int   blinks     = 0;
  logic prev_led   = 1'b0;

  // Reference model: phase 0 idle, 1 on, 2 gap; m_left = cycles left in phase.
  int   m_phase = 0;
  int   m_left  = 0;
  logic m_pend  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp();
    sb.push_back(exp_t'{led: (m_phase == 1), busy: (m_phase != 0), pend: m_pend});
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, ".led"},  {31'd0, bus.led_o},  {31'd0, e.led});
      check({tag, ".busy"}, {31'd0, bus.busy_o}, {31'd0, e.busy});
      check({tag, ".pend"}, {31'd0, bus.pend_o}, {31'd0, e.pend});
    end
  endtask

  task automatic model_step(input logic t);
    case (m_phase)
      0: if (t) begin m_phase = 1; m_left = ON; end
      1: begin
        if (RETRIG && t) begin
          m_left = ON;
        end else begin
          if (t) m_pend = 1'b1;
          m_left--;
          if (m_left == 0) begin m_phase = 2; m_left = OFF; end
        end
      end
      default: begin
        if (m_left == 1) begin
          if (m_pend || t) begin m_phase = 1; m_left = ON; m_pend = 1'b0; end
          else m_phase = 0;
        end else begin
          m_left--;
          if (t) m_pend = 1'b1;
        end
      end
    endcase
    push_exp();
  endtask

  task automatic steps(input int n, input logic t, input string tag);
    for (int i = 0; i < n; i++) begin
      bus.tick_i = t;
      model_step(t);
      @(posedge clk_i);
      #1;
      edge_n++;
      pop_check($sformatf("%s.e%0d", tag, edge_n));
      if (bus.led_o && !prev_led) blinks++;
      prev_led = bus.led_o;
    end
  endtask

  task automatic do_reset(input string tag);
    bus.tick_i = 1'b0;
    rst_i = 1'b1;
    m_phase = 0; m_left = 0; m_pend = 1'b0;
    #1;
    push_exp();
    pop_check({tag, ".rst"});
    @(negedge clk_i);
    rst_i = 1'b0;
    push_exp();
    @(posedge clk_i);
    #1;
    pop_check({tag, ".rel"});
    edge_n = 0; blinks = 0; prev_led = 1'b0;
  endtask

  initial begin
    bus.tick_i = 1'b0;

    // Single tick at edge 10.
    do_reset("s1");
    steps(9, 1'b0, "s1");
    steps(1, 1'b1, "s1");
    steps(3, 1'b0, "s1");
    check("s1.led_e13", {31'd0, bus.led_o}, 32'd1);
    steps(1, 1'b0, "s1");
    check("s1.led_e14", {31'd0, bus.led_o}, 32'd0);
    steps(2, 1'b0, "s1");
    check("s1.busy_e16", {31'd0, bus.busy_o}, 32'd1);
    steps(1, 1'b0, "s1");
    check("s1.busy_e17", {31'd0, bus.busy_o}, 32'd0);
    steps(5, 1'b0, "s1");
    check("s1.blinks", blinks, 32'd1);

    // Ticks at edges 10 and 12.
    do_reset("s2");
    steps(9, 1'b0, "s2");
    steps(1, 1'b1, "s2");
    steps(1, 1'b0, "s2");
    steps(1, 1'b1, "s2");
`ifndef LED_STRETCH_RETRIGGER_EN
    check("s2.pend_e12", {31'd0, bus.pend_o}, 32'd1);
    steps(5, 1'b0, "s2");
    check("s2.led_e17", {31'd0, bus.led_o}, 32'd1);
    check("s2.pend_e17", {31'd0, bus.pend_o}, 32'd0);
    steps(3, 1'b0, "s2");
    check("s2.led_e20", {31'd0, bus.led_o}, 32'd1);
    steps(1, 1'b0, "s2");
    check("s2.led_e21", {31'd0, bus.led_o}, 32'd0);
    steps(8, 1'b0, "s2");
    check("s2.blinks", blinks, 32'd2);
`else
    steps(3, 1'b0, "s2");
    check("s2.led_e15", {31'd0, bus.led_o}, 32'd1);
    steps(1, 1'b0, "s2");
    check("s2.led_e16", {31'd0, bus.led_o}, 32'd0);
    steps(8, 1'b0, "s2");
    check("s2.blinks", blinks, 32'd1);
`endif

    // Ticks at edges 10, 12, 13, 15: a burst collapses into one extra blink.
    do_reset("s3");
    steps(9, 1'b0, "s3");
    steps(1, 1'b1, "s3");
    steps(1, 1'b0, "s3");
    steps(2, 1'b1, "s3");
    steps(1, 1'b0, "s3");
    steps(1, 1'b1, "s3");
    steps(16, 1'b0, "s3");
    check("s3.blinks", blinks, 32'd2);

    // Tick consumed in the terminal gap cycle: no idle cycle in between.
    do_reset("s4");
    steps(9, 1'b0, "s4");
    steps(1, 1'b1, "s4");
    steps(6, 1'b0, "s4");
    check("s4.led_e16", {31'd0, bus.led_o}, 32'd0);
    check("s4.busy_e16", {31'd0, bus.busy_o}, 32'd1);
    steps(1, 1'b1, "s4");
    check("s4.led_e17", {31'd0, bus.led_o}, 32'd1);
    check("s4.busy_e17", {31'd0, bus.busy_o}, 32'd1);
    check("s4.pend_e17", {31'd0, bus.pend_o}, 32'd0);
    steps(10, 1'b0, "s4");

    // tick_i held high for 20 cycles (edges 10..29).
    do_reset("s5");
    steps(9, 1'b0, "s5");
    steps(20, 1'b1, "s5");
    steps(15, 1'b0, "s5");
`ifndef LED_STRETCH_RETRIGGER_EN
    check("s5.blinks", blinks, 32'd4);
`else
    check("s5.blinks", blinks, 32'd1);
`endif

    // Reset asserted mid-ON with an event pending; no blink afterwards.
    do_reset("s6");
    steps(9, 1'b0, "s6");
    steps(2, 1'b1, "s6");
`ifndef LED_STRETCH_RETRIGGER_EN
    check("s6.pend_pre", {31'd0, bus.pend_o}, 32'd1);
`endif
    check("s6.led_pre", {31'd0, bus.led_o}, 32'd1);
    #2;
    do_reset("s6");
    steps(15, 1'b0, "s6");
    check("s6.blinks", blinks, 32'd0);

    check("sb.drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
